iic_arbiter: RTL and testbench
==============================

# iic_arbiter

Round-robin arbiter that shares one IIC_M master between N_REQ client blocks (sensor init, EEPROM access, runtime register pokes). It captures the winning client's command, launches one IIC_M transaction, steers the byte-level write/read handshakes to that client, and reports completion or timeout. It sits directly between the clients and the IIC_M user port.

## Interface
- N_REQ, 4, number of clients (2..8)
- DATA_WIDTH, 8, data byte width, matches IIC_M
- LEN_WIDTH, 8, width of write/read length fields
- TIMEOUT_CYCLES, 1_000_000, max sysclk cycles from launch to m_done (20 ms at 50 MHz)
- sysclk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- c_req  in  N_REQ  per-client request, level, held until that client's c_done
- c_mode  in  N_REQ  per-client mode, 0 write, 1 read
- c_dev  in  N_REQ*7  per-client 7-bit device address, client i at [7i+6:7i]
- c_reg  in  N_REQ*16  per-client register address
- c_wlen, c_rlen  in  N_REQ*LEN_WIDTH each  per-client write/read byte counts
- c_wr_data  in  N_REQ*DATA_WIDTH  per-client next write byte
- c_wr_valid  out  N_REQ  write-byte strobe, routed to granted client only
- c_rd_data  out  DATA_WIDTH  read byte, broadcast to all clients
- c_rd_valid  out  N_REQ  read-byte strobe, routed to granted client only
- c_grant  out  N_REQ  one-hot, high for whole transaction of granted client
- c_done  out  N_REQ  one-cycle completion pulse to granted client
- c_err  out  N_REQ  one-cycle, coincident with c_done when transaction timed out
- arb_busy  out  1  high in any state other than IDLE
- m_req  out  1  one-cycle launch pulse to IIC_M iic_req
- m_mode, m_dev[6:0], m_reg[15:0], m_wlen, m_rlen  out  latched command to IIC_M
- m_wr_data  out  DATA_WIDTH  c_wr_data slice of granted client (combinational mux)
- m_wr_valid  in  1  IIC_M iic_wr_valid
- m_rd_data  in  DATA_WIDTH  IIC_M iic_rd_data
- m_rd_valid  in  1  IIC_M iic_rd_valid
- m_busy, m_done  in  1 each  IIC_M iic_busy / iic_done

## Operation
- States: IDLE, GRANT, LAUNCH, WAIT_BUSY, WAIT_DONE, FINISH.
- IDLE: if any c_req bit set, select winner by round-robin, go GRANT. Search starts at last_grant+1 mod N_REQ; reset sets last_grant=N_REQ-1 so client 0 has top priority first.
- GRANT: c_grant one-hot asserted; winner's mode/dev/reg/wlen/rlen registered onto m_* outputs; held constant until IDLE. Go LAUNCH.
- LAUNCH: m_req=1 for exactly one cycle; timeout counter cleared; go WAIT_BUSY.
- WAIT_BUSY: wait for m_busy=1 → WAIT_DONE; m_done=1 here also accepted → FINISH.
- WAIT_DONE: wait m_done=1 → FINISH.
- FINISH: c_done[g]=1 one cycle; c_err[g]=1 if timed out; last_grant←g; c_grant cleared; go IDLE.
- Timeout: counter runs in WAIT_BUSY and WAIT_DONE; on reaching TIMEOUT_CYCLES go FINISH with error. m_req is never re-issued for that command.
- Steering: c_wr_valid = m_wr_valid & c_grant; c_rd_valid = m_rd_valid & c_grant; c_rd_data = m_rd_data. Strobes outside WAIT_BUSY/WAIT_DONE are dropped (all zero).
- Clients must drop c_req in the cycle after c_done; a c_req still high when IDLE is next evaluated is a new transaction.
- Changes to a granted client's command fields after GRANT are ignored.

## Timing
- Reset: all outputs 0, state IDLE, last_grant=N_REQ-1, counter 0; reset mid-transaction abandons it with no c_done.
- Latency: c_req seen at edge k (IDLE) → c_grant high after edge k+1 → m_req high during cycle after edge k+2.
- m_done at edge j → c_done high during cycle after edge j+1, arb_busy low after edge j+2.
- Minimum gap between consecutive m_req pulses: 4 cycles.
- m_wr_data is combinational from c_wr_data; client presents byte same cycle as c_wr_valid, as IIC_M expects.
- Simultaneous requests: exactly one bit in c_grant; no client starves (worst wait N_REQ-1 transactions).

## Test plan
- Single client 0 write, wlen=5, dev=7'h03, reg=16'h0001: m_req pulse 2 cycles after c_req, m_dev=7'h03, m_reg=16'h0001, 5 c_wr_valid[0] pulses, c_done[0]=1, c_err=0.
- Clients 1 and 3 request same cycle after reset: client 1 served first, then 3; c_grant never has two bits set.
- All 4 clients hold c_req continuously for 8 transactions: grant order 0,1,2,3,0,1,2,3.
- Client 2 read rlen=3 with mock returning 8'hA5,8'h5A,8'h3C: only c_rd_valid[2] pulses, c_rd_data matches in order.
- Mock never asserts m_busy/m_done, TIMEOUT_CYCLES=100: c_done and c_err pulse together 100 cycles after launch, single m_req.
- Assert rst during WAIT_DONE: all outputs 0 next cycle, no c_done, next request granted to client 0.

Source files
------------

// File: rtl/iic_arbiter.sv
// iic_arbiter: round-robin sharing of one IIC_M master between N_REQ clients.
// Captures the winner's command, launches one IIC_M transaction, steers the
// byte strobes to the winner and reports completion or timeout.
module iic_arbiter #(
  parameter int unsigned N_REQ          = 4,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned LEN_WIDTH      = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                          sysclk,
  input  logic                          rst,
  input  logic [N_REQ-1:0]              c_req,
  input  logic [N_REQ-1:0]              c_mode,
  input  logic [N_REQ*7-1:0]            c_dev,
  input  logic [N_REQ*16-1:0]           c_reg,
  input  logic [N_REQ*LEN_WIDTH-1:0]    c_wlen,
  input  logic [N_REQ*LEN_WIDTH-1:0]    c_rlen,
  input  logic [N_REQ*DATA_WIDTH-1:0]   c_wr_data,
  output logic [N_REQ-1:0]              c_wr_valid,
  output logic [DATA_WIDTH-1:0]         c_rd_data,
  output logic [N_REQ-1:0]              c_rd_valid,
  output logic [N_REQ-1:0]              c_grant,
  output logic [N_REQ-1:0]              c_done,
  output logic [N_REQ-1:0]              c_err,
  output logic                          arb_busy,
  output logic                          m_req,
  output logic                          m_mode,
  output logic [6:0]                    m_dev,
  output logic [15:0]                   m_reg,
  output logic [LEN_WIDTH-1:0]          m_wlen,
  output logic [LEN_WIDTH-1:0]          m_rlen,
  output logic [DATA_WIDTH-1:0]         m_wr_data,
  input  logic                          m_wr_valid,
  input  logic [DATA_WIDTH-1:0]         m_rd_data,
  input  logic                          m_rd_valid,
  input  logic                          m_busy,
  input  logic                          m_done
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, GRANT, LAUNCH, WAIT_BUSY, WAIT_DONE, FINISH
  } state_e;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       win_q, win_d;
  logic [IDX_W-1:0]       last_q, last_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   to_q, to_d;
  logic [N_REQ-1:0]       grant_q, grant_d;
  logic [N_REQ-1:0]       done_q, done_d;
  logic [N_REQ-1:0]       err_q, err_d;
  logic                   busy_q, busy_d;
  logic                   mreq_q, mreq_d;
  logic                   mmode_q, mmode_d;
  logic [6:0]             mdev_q, mdev_d;
  logic [15:0]            mreg_q, mreg_d;
  logic [LEN_WIDTH-1:0]   mwlen_q, mwlen_d;
  logic [LEN_WIDTH-1:0]   mrlen_q, mrlen_d;

  logic [IDX_W-1:0]       rr_idx, rr_win;
  logic                   rr_found;
  logic                   sel_mode;
  logic [6:0]             sel_dev;
  logic [15:0]            sel_reg;
  logic [LEN_WIDTH-1:0]   sel_wlen, sel_rlen;
  logic [DATA_WIDTH-1:0]  sel_wr_data;
  logic [CNT_W-1:0]       cnt_inc;
  logic                   timeout_hit;
  logic                   in_wait;

  // Round-robin pick: first requester after the last granted client.
  always_comb begin
    rr_idx   = '0;
    rr_win   = last_q;
    rr_found = 1'b0;
    for (int unsigned off = 1; off <= N_REQ; off++) begin
      rr_idx = IDX_W'((32'(last_q) + off) % N_REQ);
      if (!rr_found && c_req[rr_idx]) begin
        rr_win   = rr_idx;
        rr_found = 1'b1;
      end
    end
  end

  // Per-client field mux driven by the registered winner index.
  always_comb begin
    sel_mode    = 1'b0;
    sel_dev     = '0;
    sel_reg     = '0;
    sel_wlen    = '0;
    sel_rlen    = '0;
    sel_wr_data = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (win_q == IDX_W'(i)) begin
        sel_mode    = c_mode[i];
        sel_dev     = c_dev[7*i +: 7];
        sel_reg     = c_reg[16*i +: 16];
        sel_wlen    = c_wlen[LEN_WIDTH*i +: LEN_WIDTH];
        sel_rlen    = c_rlen[LEN_WIDTH*i +: LEN_WIDTH];
        sel_wr_data = c_wr_data[DATA_WIDTH*i +: DATA_WIDTH];
      end
    end
  end

  assign cnt_inc     = cnt_q + CNT_W'(1);
  assign timeout_hit = (cnt_inc == CNT_W'(TIMEOUT_CYCLES));

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    grant_d = grant_q;
    done_d  = '0;
    err_d   = '0;
    busy_d  = (state_q != IDLE);
    mreq_d  = 1'b0;
    mmode_d = mmode_q;
    mdev_d  = mdev_q;
    mreg_d  = mreg_q;
    mwlen_d = mwlen_q;
    mrlen_d = mrlen_q;
    case (state_q)
      IDLE: begin
        if (rr_found) begin
          win_d   = rr_win;
          state_d = GRANT;
        end
      end
      GRANT: begin
        grant_d = N_REQ'(1) << win_q;
        mmode_d = sel_mode;
        mdev_d  = sel_dev;
        mreg_d  = sel_reg;
        mwlen_d = sel_wlen;
        mrlen_d = sel_rlen;
        state_d = LAUNCH;
      end
      LAUNCH: begin
        mreq_d  = 1'b1;
        cnt_d   = '0;
        to_d    = 1'b0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY, WAIT_DONE: begin
        cnt_d = cnt_inc;
        if (m_done) begin
          state_d = FINISH;
        end else if (timeout_hit) begin
          to_d    = 1'b1;
          state_d = FINISH;
        end else if (m_busy) begin
          state_d = WAIT_DONE;
        end
      end
      FINISH: begin
        done_d  = grant_q;
        err_d   = to_q ? grant_q : '0;
        last_d  = win_q;
        grant_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any transaction.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      win_q   <= '0;
      last_q  <= IDX_W'(N_REQ - 1);
      cnt_q   <= '0;
      to_q    <= 1'b0;
      grant_q <= '0;
      done_q  <= '0;
      err_q   <= '0;
      busy_q  <= 1'b0;
      mreq_q  <= 1'b0;
      mmode_q <= 1'b0;
      mdev_q  <= '0;
      mreg_q  <= '0;
      mwlen_q <= '0;
      mrlen_q <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      mreq_q  <= mreq_d;
      mmode_q <= mmode_d;
      mdev_q  <= mdev_d;
      mreg_q  <= mreg_d;
      mwlen_q <= mwlen_d;
      mrlen_q <= mrlen_d;
    end
  end

  // Byte strobes pass through only while a transaction is in flight.
  assign in_wait    = (state_q == WAIT_BUSY) || (state_q == WAIT_DONE);
  assign c_wr_valid = (in_wait && m_wr_valid) ? grant_q : '0;
  assign c_rd_valid = (in_wait && m_rd_valid) ? grant_q : '0;
  assign c_rd_data  = m_rd_data;
  assign m_wr_data  = sel_wr_data;

  assign c_grant  = grant_q;
  assign c_done   = done_q;
  assign c_err    = err_q;
  assign arb_busy = busy_q;
  assign m_req    = mreq_q;
  assign m_mode   = mmode_q;
  assign m_dev    = mdev_q;
  assign m_reg    = mreg_q;
  assign m_wlen   = mwlen_q;
  assign m_rlen   = mrlen_q;

endmodule

// File: tb/tb_iic_arbiter.sv
// Directed self-checking bench for iic_arbiter with a hand-driven IIC_M mock.
module tb_iic_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned LW = 8;
  localparam int unsigned TO = 100;

  logic            sysclk = 1'b0;
  logic            rst;
  logic [N-1:0]    c_req, c_mode;
  logic [N*7-1:0]  c_dev;
  logic [N*16-1:0] c_reg;
  logic [N*LW-1:0] c_wlen, c_rlen;
  logic [N*DW-1:0] c_wr_data;
  logic [N-1:0]    c_wr_valid, c_rd_valid, c_grant, c_done, c_err;
  logic [DW-1:0]   c_rd_data;
  logic            arb_busy, m_req, m_mode;
  logic [6:0]      m_dev;
  logic [15:0]     m_reg;
  logic [LW-1:0]   m_wlen, m_rlen;
  logic [DW-1:0]   m_wr_data, m_rd_data;
  logic            m_wr_valid, m_rd_valid, m_busy, m_done;

  int n_tests = 0;
  int n_fail  = 0;

  iic_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .TIMEOUT_CYCLES(TO)) dut (
    .sysclk(sysclk), .rst(rst),
    .c_req(c_req), .c_mode(c_mode), .c_dev(c_dev), .c_reg(c_reg),
    .c_wlen(c_wlen), .c_rlen(c_rlen), .c_wr_data(c_wr_data),
    .c_wr_valid(c_wr_valid), .c_rd_data(c_rd_data), .c_rd_valid(c_rd_valid),
    .c_grant(c_grant), .c_done(c_done), .c_err(c_err), .arb_busy(arb_busy),
    .m_req(m_req), .m_mode(m_mode), .m_dev(m_dev), .m_reg(m_reg),
    .m_wlen(m_wlen), .m_rlen(m_rlen), .m_wr_data(m_wr_data),
    .m_wr_valid(m_wr_valid), .m_rd_data(m_rd_data), .m_rd_valid(m_rd_valid),
    .m_busy(m_busy), .m_done(m_done)
  );

  always #5 sysclk = ~sysclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_cmd(input int idx, input logic mode, input logic [6:0] dev,
                         input logic [15:0] rg, input logic [7:0] wl, input logic [7:0] rl);
    c_mode[idx]          = mode;
    c_dev[7*idx +: 7]    = dev;
    c_reg[16*idx +: 16]  = rg;
    c_wlen[LW*idx +: LW] = wl;
    c_rlen[LW*idx +: LW] = rl;
  endtask

  // Returns at the negedge where m_req is seen high.
  task automatic wait_mreq(input string tag);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge sysclk);
      if (m_req) begin
        got = 1'b1;
        break;
      end
    end
    check(tag, got, 1'b1);
  endtask

  // Mock IIC_M: busy, then a done pulse; waits for c_done to the expected client.
  task automatic complete(input string tag, input logic [N-1:0] g, input logic drop);
    logic got;
    m_busy = 1'b1;
    @(negedge sysclk);
    m_busy = 1'b0;
    m_done = 1'b1;
    @(negedge sysclk);
    m_done = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge sysclk);
      if (c_done != '0) begin
        got = 1'b1;
        break;
      end
    end
    check({tag, "_done_seen"}, got, 1'b1);
    check({tag, "_done"}, c_done, g);
    check({tag, "_err"}, c_err, '0);
    if (drop) c_req = c_req & ~g;
  endtask

  task automatic serve(input string tag, input logic [N-1:0] exp_g, input logic drop);
    logic [N-1:0] g;
    wait_mreq({tag, "_mreq"});
    g = c_grant;
    check({tag, "_onehot"}, $onehot(g), 1'b1);
    check({tag, "_grant"}, g, exp_g);
    complete(tag, g, drop);
  endtask

  logic [7:0] rd_bytes [3];
  logic [3:0] rr_exp   [8];
  int         wr_cnt;
  int         n_cyc;
  int         mreq_cnt;
  logic       got_done;

  initial begin
    rd_bytes = '{8'hA5, 8'h5A, 8'h3C};
    rr_exp   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    rst = 1'b1;
    c_req = '0; c_mode = '0; c_dev = '0; c_reg = '0; c_wlen = '0; c_rlen = '0; c_wr_data = '0;
    m_wr_valid = 1'b0; m_rd_data = '0; m_rd_valid = 1'b0; m_busy = 1'b0; m_done = 1'b0;
    for (int i = 0; i < N; i++)
      set_cmd(i, 1'b0, 7'(7'h10 + i), 16'(16'h1000 + i), 8'(i + 1), 8'(i + 2));
    set_cmd(0, 1'b0, 7'h03, 16'h0001, 8'd5, 8'd0);
    repeat (3) @(negedge sysclk);
    rst = 1'b0;
    #1;
    check("rst_grant", c_grant, '0);
    check("rst_busy", arb_busy, 1'b0);
    check("rst_mreq", m_req, 1'b0);
    check("rst_done_err", {c_done, c_err}, '0);
    check("rst_mfields", {m_mode, m_dev, m_reg, m_wlen, m_rlen}, '0);

    // Client 0 write, wlen=5; latency and field capture.
    @(negedge sysclk);
    c_req = 4'b0001;
    @(negedge sysclk);
    check("t1_grant_not_yet", c_grant, '0);
    @(negedge sysclk);
    check("t1_grant", c_grant, 4'b0001);
    check("t1_busy", arb_busy, 1'b1);
    check("t1_mreq_not_yet", m_req, 1'b0);
    check("t1_fields", {m_mode, m_dev, m_reg, m_wlen}, {1'b0, 7'h03, 16'h0001, 8'd5});
    m_wr_valid = 1'b1;
    m_rd_valid = 1'b1;
    #1;
    check("t1_strobe_drop", {c_wr_valid, c_rd_valid}, '0);
    m_wr_valid = 1'b0;
    m_rd_valid = 1'b0;
    @(negedge sysclk);
    check("t1_mreq", m_req, 1'b1);
    c_dev[6:0] = 7'h7F;
    m_busy = 1'b1;
    wr_cnt = 0;
    for (int p = 0; p < 5; p++) begin
      @(negedge sysclk);
      c_wr_data[7:0] = 8'(8'hB0 + p);
      m_wr_valid = 1'b1;
      #1;
      check("t1_wr_valid", c_wr_valid, 4'b0001);
      check("t1_wr_data", m_wr_data, 8'(8'hB0 + p));
      if (c_wr_valid[0]) wr_cnt++;
      @(negedge sysclk);
      m_wr_valid = 1'b0;
      #1;
      check("t1_wr_idle", c_wr_valid, '0);
    end
    check("t1_wr_count", wr_cnt, 5);
    check("t1_dev_held", m_dev, 7'h03);
    check("t1_single_mreq", m_req, 1'b0);
    m_busy = 1'b0;
    m_done = 1'b1;
    @(negedge sysclk);
    m_done = 1'b0;
    check("t1_done_not_yet", c_done, '0);
    @(negedge sysclk);
    check("t1_done", c_done, 4'b0001);
    check("t1_err", c_err, '0);
    check("t1_grant_clr", c_grant, '0);
    c_req = '0;
    c_dev[6:0] = 7'h03;
    @(negedge sysclk);
    check("t1_busy_low", arb_busy, 1'b0);
    check("t1_done_pulse", c_done, '0);

    // Clients 1 and 3 together after reset: 1 first, then 3.
    rst = 1'b1;
    @(negedge sysclk);
    rst = 1'b0;
    c_req = 4'b1010;
    serve("t2a", 4'b0010, 1'b1);
    serve("t2b", 4'b1000, 1'b1);

    // All four clients hold their requests for eight transactions.
    c_req = 4'b1111;
    for (int t = 0; t < 8; t++) serve("t3", rr_exp[t], 1'b0);
    c_req = '0;

    // Client 2 read of three bytes.
    set_cmd(2, 1'b1, 7'h22, 16'h0200, 8'd0, 8'd3);
    @(negedge sysclk);
    c_req = 4'b0100;
    wait_mreq("t4_mreq");
    check("t4_grant", c_grant, 4'b0100);
    check("t4_fields", {m_mode, m_dev, m_rlen}, {1'b1, 7'h22, 8'd3});
    m_busy = 1'b1;
    for (int b = 0; b < 3; b++) begin
      @(negedge sysclk);
      m_rd_data = rd_bytes[b];
      m_rd_valid = 1'b1;
      #1;
      check("t4_rd_valid", c_rd_valid, 4'b0100);
      check("t4_rd_data", c_rd_data, rd_bytes[b]);
      @(negedge sysclk);
      m_rd_valid = 1'b0;
      #1;
      check("t4_rd_idle", c_rd_valid, '0);
    end
    complete("t4", 4'b0100, 1'b1);

    // Timeout: mock stays silent; c_done/c_err come TO wait cycles plus FINISH after m_req.
    @(negedge sysclk);
    c_req = 4'b0010;
    wait_mreq("t5_mreq");
    n_cyc = 0;
    mreq_cnt = 1;
    got_done = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge sysclk);
      n_cyc++;
      if (m_req) mreq_cnt++;
      if (c_done != '0) begin
        got_done = 1'b1;
        break;
      end
    end
    check("t5_done_seen", got_done, 1'b1);
    check("t5_latency", n_cyc, TO + 1);
    check("t5_done", c_done, 4'b0010);
    check("t5_err", c_err, 4'b0010);
    check("t5_mreq_count", mreq_cnt, 1);
    c_req = '0;
    @(negedge sysclk);
    check("t5_err_pulse", {c_done, c_err}, '0);

    // Reset during WAIT_DONE abandons the transaction.
    c_req = 4'b1000;
    wait_mreq("t6_mreq");
    m_busy = 1'b1;
    @(negedge sysclk);
    rst = 1'b1;
    #1;
    check("t6_rst_outs", {c_grant, c_done, c_err, arb_busy, m_req}, '0);
    check("t6_rst_fields", {m_dev, m_reg}, '0);
    @(negedge sysclk);
    rst = 1'b0;
    m_busy = 1'b0;
    c_req = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge sysclk);
      check("t6_no_done", c_done, '0);
    end
    c_req = 4'b1001;
    serve("t6a", 4'b0001, 1'b1);
    serve("t6b", 4'b1000, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
